loop_step_sequencer: RTL and testbench
======================================

# loop_step_sequencer

Sequencing controller for the 15-bit arithmetic loop kernel (registers `i`, `x`, `y`, branch input `selector`). It accepts a start command with an iteration bound, clears the kernel, and issues one `step_en` per loop iteration, forwarding the per-step branch choice. It supports pause and abort, and reports iteration and branch-taken counts. It sits between the test/control harness and the kernel datapath and owns all of the kernel's enables.

## Interface
- `W`, 15, width of the bound and all counters (matches the kernel datapath width)

- `clk`  input  1  system clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  run request; sampled only in IDLE
- `bound`  input  W  iteration count; latched on accepted `start`
- `selector`  input  1  branch choice for the current step
- `pause`  input  1  stall; suppresses stepping while in RUN
- `abort`  input  1  cancel the run; effective in CLEAR and RUN
- `kernel_clr`  output  1  one-cycle clear pulse to the kernel registers
- `step_en`  output  1  kernel advance-one-iteration enable
- `branch_sel`  output  1  branch select to the kernel; valid when `step_en`=1
- `iter`  output  W  completed step count for the current run
- `taken_cnt`  output  W  steps issued with `selector`=1 in the current run
- `busy`  output  1  run in progress
- `done`  output  1  one-cycle completion pulse
- `aborted`  output  1  one-cycle abort pulse

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE. The state is registered.
- IDLE
  - `start`=1 and `bound`≠0: latch `bound` into `bound_q`, go to CLEAR.
  - `start`=1 and `bound`=0: go to DONE directly. No clear, no steps.
- CLEAR
  - `kernel_clr`=1.
  - `iter` and `taken_cnt` load 0.
  - Next state is RUN, or IDLE if `abort`=1.
- RUN
  - `step_en` = !`pause` && !`abort`. This is combinational from state and inputs.
  - `branch_sel` = `selector` (passthrough). It is driven 0 when `step_en`=0.
  - On each edge with `step_en`=1:
    - `iter` <= `iter`+1.
    - `taken_cnt` <= `taken_cnt` + `selector`.
    - If `iter`+1 == `bound_q`, go to DONE.
  - `pause`=1: hold all state and counters.
- DONE
  - `done`=1 for exactly one cycle, then IDLE.
  - `iter` and `taken_cnt` hold their final values until the next accepted `start`.
- Abort
  - `abort`=1 in CLEAR or RUN: IDLE on the next edge.
  - `aborted`=1 for one cycle, during the first IDLE cycle.
  - No `done`. Counters hold their partial values.
  - `abort` has priority over `pause` and over the final step (a final step with `abort` high is not issued).
  - `abort` in IDLE or DONE is ignored.
- `busy` = state is CLEAR or RUN.
- `start` while `busy` or in DONE is ignored and not queued.
- Width rules
  - Counters are unsigned W-bit.
  - `iter` never exceeds `bound_q`, so there is no wrap.
  - The maximum run is 2^W−1 = 32767 steps.
  - `taken_cnt` ≤ `iter` always.
- Reset (async, immediate)
  - State = IDLE.
  - `iter`, `taken_cnt`, and `bound_q` = 0.
  - `kernel_clr`, `step_en`, `branch_sel`, `busy`, `done`, `aborted` = 0.
  - Reset mid-run discards the run with no `done` and no `aborted`.

## Timing
- `start` sampled at edge k (`bound`=N>0):
  - CLEAR in cycle k+1, with `kernel_clr`=1 and `busy`=1.
  - RUN from cycle k+2.
- With no pause:
  - `step_en` is high in cycles k+2 … k+N+1.
  - `done` is high in cycle k+N+2.
  - Next `start` accepted at edge k+N+3 at the earliest.
- Each cycle of `pause` in RUN delays `done` by exactly one cycle.
- `bound`=0: `done` in cycle k+1. `busy` stays 0 and `kernel_clr` stays 0.
- `iter` updates at the edge that ends a `step_en` cycle. In cycle k+N+2, `iter`=N.
- `done`, `aborted`, and `kernel_clr` are registered-state decodes and are glitch-free.
- `step_en` and `branch_sel` have a combinational path from `pause`, `abort`, and `selector`.

## Test plan
- Basic run: `bound`=5, `selector`=1,0,1,1,0, no pause.
  - One `kernel_clr` pulse.
  - Exactly 5 `step_en` cycles, with `branch_sel` equal to `selector`.
  - `done` 7 cycles after the `start` edge.
  - `iter`=5, `taken_cnt`=3.
- Pause: `bound`=4, `pause` high for 3 cycles after the second step.
  - Exactly 4 steps.
  - `done` at k+9.
  - No `step_en` while paused.
  - Counters frozen while paused.
- Zero bound: `start` with `bound`=0.
  - `done` at k+1.
  - No `kernel_clr`, no `step_en`, `busy` never high.
- Abort: `bound`=10, `abort` in the cycle of the 4th step.
  - That step is suppressed; `iter`=3.
  - `aborted` pulse; no `done`; IDLE.
  - A new `start` is then accepted.
- Start while busy: second `start` (`bound`=2) during a `bound`=6 run.
  - Ignored; exactly 6 steps.
  - `bound_q` unchanged; one `done`.
- Async reset mid-RUN (`iter`=3, `bound`=8).
  - All outputs 0 immediately, before the next clock edge.
  - No `done`, no `aborted`.
  - A max run of `bound`=32767 afterwards completes with `iter`=32767 and no wrap.

Source files
------------

// File: rtl/loop_step_sequencer.sv
// Purpose: sequencing controller for the 15-bit loop kernel (clear, per-iteration step enables, pause/abort, counts).
// Latency: start edge -> kernel_clr next cycle -> first step_en the cycle after; done one cycle after the last step.
// Backpressure: pause stalls stepping cycle-for-cycle; start is ignored (not queued) while busy or in DONE.
module loop_step_sequencer #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bound,
    input  logic         selector,
    input  logic         pause,
    input  logic         abort,
    output logic         kernel_clr,
    output logic         step_en,
    output logic         branch_sel,
    output logic [W-1:0] iter,
    output logic [W-1:0] taken_cnt,
    output logic         busy,
    output logic         done,
    output logic         aborted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state;
    logic [W-1:0] bound_q;
    logic [W-1:0] iter_inc;
    logic [W-1:0] sel_ext;

    assign iter_inc = iter + W'(1);
    assign sel_ext  = {{(W-1){1'b0}}, selector};

    // Step enable and branch select stay combinational so the kernel sees pause/abort in the same cycle.
    always_comb begin
        step_en    = (state == RUN) && !pause && !abort;
        branch_sel = step_en && selector;
    end

    // Control FSM; kernel_clr/busy/done/aborted are flops loaded alongside the next state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bound_q    <= '0;
            iter       <= '0;
            taken_cnt  <= '0;
            kernel_clr <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            kernel_clr <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bound != '0) begin
                            bound_q    <= bound;
                            kernel_clr <= 1'b1;
                            busy       <= 1'b1;
                            state      <= CLEAR;
                        end else begin
                            // An empty run completes immediately with zero steps counted.
                            iter      <= '0;
                            taken_cnt <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    iter      <= '0;
                    taken_cnt <= '0;
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Abort wins over pause and over a final step; partial counts are kept.
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (!pause) begin
                        iter      <= iter_inc;
                        taken_cnt <= taken_cnt + sel_ext;
                        if (iter_inc == bound_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_step_sequencer.sv
// Scoreboard bench for loop_step_sequencer: stimulus pushes expected events, a negedge monitor pops and compares.
// Cycle numbering: cycle c is the cycle ending at edge c; a start driven in cycle k is sampled at edge k.
// Events: kernel_clr, each step_en, done and aborted, each tagged with its cycle and relevant values.
module tb_loop_step_sequencer;

    localparam int W = 15;
    localparam int K_CLR  = 0;
    localparam int K_STEP = 1;
    localparam int K_DONE = 2;
    localparam int K_ABRT = 3;

    typedef struct {
        int kind;
        int cyc;
        int v1;
        int v2;
    } ev_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] bound;
    logic         selector;
    logic         pause;
    logic         abort;
    logic         kernel_clr;
    logic         step_en;
    logic         branch_sel;
    logic [W-1:0] iter;
    logic [W-1:0] taken_cnt;
    logic         busy;
    logic         done;
    logic         aborted;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    loop_step_sequencer #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bound      (bound),
        .selector   (selector),
        .pause      (pause),
        .abort      (abort),
        .kernel_clr (kernel_clr),
        .step_en    (step_en),
        .branch_sel (branch_sel),
        .iter       (iter),
        .taken_cnt  (taken_cnt),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    task automatic push(input int kind, input int c, input int v1, input int v2);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.v1   = v1;
        e.v2   = v2;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int v1, input int v2);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d cycle=%0d v1=%0d v2=%0d, expected no event",
                     kind, cyc + 1, v1, v2);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc + 1 || e.v1 != v1 || e.v2 != v2) begin
                failures++;
                $display("FAIL event: got kind=%0d cycle=%0d v1=%0d v2=%0d, expected kind=%0d cycle=%0d v1=%0d v2=%0d",
                         kind, cyc + 1, v1, v2, e.kind, e.cyc, e.v1, e.v2);
            end
        end
    endtask

    // Monitor: sample away from the active edge and reconcile every DUT event with the scoreboard.
    always @(negedge clk) begin
        if (kernel_clr) observe(K_CLR, int'(busy), 0);
        if (step_en)    observe(K_STEP, int'(branch_sel), int'(iter));
        if (done)       observe(K_DONE, int'(iter), int'(taken_cnt));
        if (aborted)    observe(K_ABRT, int'(iter), int'(taken_cnt));
        if (!step_en && selector) check("branch_sel_gated", int'(branch_sel), 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cur();
        return cyc + 1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        int s1[5] = '{1, 0, 1, 1, 0};

        rst = 1'b1; start = 1'b0; bound = '0; selector = 1'b0; pause = 1'b0; abort = 1'b0;
        tick();
        tick();
        check("rst_iter", int'(iter), 0);
        check("rst_taken", int'(taken_cnt), 0);
        check("rst_flags", int'({kernel_clr, step_en, branch_sel, busy, done, aborted}), 0);
        rst = 1'b0;
        tick();

        // Basic run: bound=5, selector 1,0,1,1,0 -> done at k+7 with iter=5, taken=3.
        start = 1'b1; bound = 15'd5; k = cur();
        push(K_CLR, k + 1, 1, 0);
        for (int j = 0; j < 5; j++) push(K_STEP, k + 2 + j, s1[j], j);
        push(K_DONE, k + 7, 5, 3);
        tick(); start = 1'b0; bound = '0;
        check("clear_busy", int'(busy), 1);
        for (int j = 0; j < 5; j++) begin
            tick(); selector = s1[j][0];
        end
        tick(); selector = 1'b0;
        tick();

        // Pause: bound=4, pause three cycles after the second step -> done at k+9.
        tick(); start = 1'b1; bound = 15'd4; k = cur();
        push(K_CLR, k + 1, 1, 0);
        push(K_STEP, k + 2, 1, 0);
        push(K_STEP, k + 3, 0, 1);
        push(K_STEP, k + 7, 0, 2);
        push(K_STEP, k + 8, 1, 3);
        push(K_DONE, k + 9, 4, 2);
        tick(); start = 1'b0; bound = '0;
        tick(); selector = 1'b1;
        tick(); selector = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tick(); pause = 1'b1; selector = 1'b1;
            #1;
            check("pause_no_step", int'(step_en), 0);
            check("pause_iter_frozen", int'(iter), 2);
            check("pause_taken_frozen", int'(taken_cnt), 1);
        end
        tick(); pause = 1'b0; selector = 1'b0;
        tick(); selector = 1'b1;
        tick(); selector = 1'b0;
        tick();

        // Zero bound: done at k+1 with no clear, no steps, never busy.
        tick(); start = 1'b1; bound = '0; k = cur();
        push(K_DONE, k + 1, 0, 0);
        tick(); start = 1'b0;
        check("zero_busy_done_cycle", int'(busy), 0);
        tick();
        check("zero_busy_after", int'(busy), 0);

        // Abort in the 4th step cycle: that step suppressed, iter=3, aborted pulse, then a new start.
        tick(); start = 1'b1; bound = 15'd10; selector = 1'b1; k = cur();
        push(K_CLR, k + 1, 1, 0);
        for (int j = 0; j < 3; j++) push(K_STEP, k + 2 + j, 1, j);
        push(K_ABRT, k + 6, 3, 3);
        tick(); start = 1'b0; bound = '0;
        tick(); tick(); tick();
        tick(); abort = 1'b1;
        #1;
        check("abort_suppresses_step", int'(step_en), 0);
        tick(); abort = 1'b0;
        check("abort_not_busy", int'(busy), 0);
        start = 1'b1; bound = 15'd1; k2 = cur();
        push(K_CLR, k2 + 1, 1, 0);
        push(K_STEP, k2 + 2, 1, 0);
        push(K_DONE, k2 + 3, 1, 1);
        tick(); start = 1'b0; bound = '0;
        tick(); tick(); selector = 1'b0;
        tick();

        // Start while busy (and during DONE) is ignored: exactly six steps, one done.
        tick(); start = 1'b1; bound = 15'd6; k = cur();
        push(K_CLR, k + 1, 1, 0);
        for (int j = 0; j < 6; j++) push(K_STEP, k + 2 + j, 0, j);
        push(K_DONE, k + 8, 6, 0);
        tick(); start = 1'b0; bound = '0;
        tick();
        tick(); start = 1'b1; bound = 15'd2;
        tick(); start = 1'b0; bound = '0;
        tick(); tick(); tick();
        tick(); start = 1'b1; bound = 15'd3;
        check("busy_low_in_done", int'(busy), 0);
        tick(); start = 1'b0; bound = '0;
        tick(); tick();

        // Async reset mid-run with iter=3 of bound=8: outputs clear before the next edge, no done/aborted.
        tick(); start = 1'b1; bound = 15'd8; k = cur();
        push(K_CLR, k + 1, 1, 0);
        for (int j = 0; j < 3; j++) push(K_STEP, k + 2 + j, 0, j);
        tick(); start = 1'b0; bound = '0;
        tick(); tick(); tick();
        tick();
        check("pre_reset_iter", int'(iter), 3);
        #1 rst = 1'b1;
        #1;
        check("async_rst_iter", int'(iter), 0);
        check("async_rst_taken", int'(taken_cnt), 0);
        check("async_rst_flags", int'({kernel_clr, step_en, branch_sel, busy, done, aborted}), 0);
        tick(); rst = 1'b0;
        tick(); tick();

        // Maximum run after reset: 32767 steps, all taken, no wrap.
        tick(); start = 1'b1; bound = 15'd32767; selector = 1'b1; k = cur();
        push(K_CLR, k + 1, 1, 0);
        for (int j = 0; j < 32767; j++) push(K_STEP, k + 2 + j, 1, j);
        push(K_DONE, k + 32769, 32767, 32767);
        tick(); start = 1'b0; bound = '0;
        repeat (32770) tick();
        selector = 1'b0;
        check("max_iter_held", int'(iter), 32767);
        check("max_taken_held", int'(taken_cnt), 32767);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
